// File: rtl/edge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : edge_pkg
// Description : Shared types, image constants and scaling helper for the
//               edge-detection result writer.
// Revision    : 1.0 - initial release
// ============================================================================
package edge_pkg;

    localparam int IMG_W         = 352;
    localparam int IMG_H         = 288;
    localparam int WORDS_PER_IMG = (IMG_W * IMG_H) / 4;
    localparam int RESULT_BASE   = WORDS_PER_IMG;

    typedef logic [7:0]  pixel_t;
    typedef logic [9:0]  sum_t;
    typedef logic [31:0] word_t;
    typedef logic [15:0] addr_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Two 10-bit magnitudes sum into 11 bits; dropping three LSBs always fits 8 bits.
    function automatic pixel_t scale_mag(input sum_t dx, input sum_t dy);
        logic [10:0] s;
        s = {1'b0, dx} + {1'b0, dy};
        return s[10:3];
    endfunction

endpackage
`default_nettype wire

// File: rtl/abs_diff.sv
`default_nettype none
// ============================================================================
// Module      : abs_diff
// Description : Combinational |p - n| of two 10-bit row/column sums.
// Revision    : 1.0 - initial release
// ============================================================================
module abs_diff
    import edge_pkg::*;
(
    input  sum_t p,
    input  sum_t n,
    output sum_t mag
);

    logic signed [10:0] w_diff;

    assign w_diff = $signed({1'b0, p}) - $signed({1'b0, n});
    assign mag    = w_diff[10] ? sum_t'(-w_diff) : sum_t'(w_diff);

endmodule
`default_nettype wire

// File: rtl/edge_writer.sv
`default_nettype none
// ============================================================================
// Module      : edge_writer
// Description : Forms |Dx|+|Dy| per pixel, packs four pixels per word and
//               writes one result image per start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_writer
    import edge_pkg::*;
#(
    parameter int WORDS = WORDS_PER_IMG,
    parameter int BASE  = RESULT_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  gx_p,
    input  logic [9:0]  gx_n,
    input  logic [9:0]  gy_p,
    input  logic [9:0]  gy_n,
    output logic        en,
    output logic        we,
    output logic [15:0] addr,
    output logic [31:0] dataW,
    output logic        finish
);

    localparam int PIX_TOTAL = 4 * WORDS;
    localparam int PCW       = $clog2(PIX_TOTAL + 1);
    localparam int WCW       = $clog2(WORDS + 1);

    state_t          r_state;
    state_t          w_state_nxt;

    logic [PCW-1:0]  r_pix_cnt;
    logic [WCW-1:0]  r_word_cnt;
    logic [1:0]      r_lane;

    logic            r_s1_valid;
    sum_t            r_dx;
    sum_t            r_dy;
    sum_t            w_dx;
    sum_t            w_dy;
    pixel_t          w_pix;

    word_t           r_word;
    word_t           w_word_nxt;

    logic            r_en;
    addr_t           r_addr;
    word_t           r_data;

    logic            w_accept;
    logic            w_last_accept;
    logic            w_begin;

    abs_diff u_abs_x (
        .p   (gx_p),
        .n   (gx_n),
        .mag (w_dx)
    );

    abs_diff u_abs_y (
        .p   (gy_p),
        .n   (gy_n),
        .mag (w_dy)
    );

    assign w_accept      = in_valid && in_ready;
    assign w_last_accept = w_accept && (r_pix_cnt == PCW'(PIX_TOTAL - 1));
    assign w_begin       = (r_state == S_IDLE) && start;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)         w_state_nxt = S_RUN;
            S_RUN:   if (w_last_accept) w_state_nxt = S_FLUSH;
            // Only the final word can be strobed while flushing.
            S_FLUSH: if (r_en)          w_state_nxt = S_DONE;
            S_DONE:                     w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready = 1'b0;
        finish   = 1'b0;
        case (r_state)
            S_RUN:   in_ready = 1'b1;
            S_DONE:  finish   = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Accept side ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_cnt  <= '0;
            r_s1_valid <= 1'b0;
            r_dx       <= '0;
            r_dy       <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_begin) begin
                r_pix_cnt <= '0;
            end else if (w_accept) begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
            end
            if (w_accept) begin
                r_dx <= w_dx;
                r_dy <= w_dy;
            end
        end
    end

    // ---------------- Scale and pack ----------------
    assign w_pix = scale_mag(r_dx, r_dy);

    always_comb begin
        w_word_nxt                        = r_word;
        w_word_nxt[{r_lane, 3'b000} +: 8] = w_pix;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane     <= '0;
            r_word_cnt <= '0;
            r_word     <= '0;
            r_en       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            r_en <= 1'b0;
            if (w_begin) begin
                r_lane     <= '0;
                r_word_cnt <= '0;
            end else if (r_s1_valid) begin
                r_word <= w_word_nxt;
                r_lane <= r_lane + 1'b1;
                if (r_lane == 2'd3) begin
                    r_en       <= 1'b1;
                    r_addr     <= addr_t'(BASE) + addr_t'(r_word_cnt);
                    r_data     <= w_word_nxt;
                    r_word_cnt <= r_word_cnt + 1'b1;
                end
            end
        end
    end

    assign en    = r_en;
    assign we    = r_en;
    assign addr  = r_addr;
    assign dataW = r_data;

endmodule
`default_nettype wire

// File: tb/tb_edge_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_writer
// Description : Directed/randomised bench with a timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_writer;

    localparam int WORDS = 3;
    localparam int BASE  = 25344;
    localparam int NPIX  = 4 * WORDS;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [9:0]  gx_p = '0, gx_n = '0, gy_p = '0, gy_n = '0;
    logic        en, we, finish;
    logic [15:0] addr;
    logic [31:0] dataW;

    edge_writer #(.WORDS(WORDS), .BASE(BASE)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .gx_p     (gx_p),
        .gx_n     (gx_n),
        .gy_p     (gy_p),
        .gy_n     (gy_n),
        .en       (en),
        .we       (we),
        .addr     (addr),
        .dataW    (dataW),
        .finish   (finish)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          waddr;
        logic [31:0] data;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] obs_d[$];
    int          obs_a[$];

    int          cyc = 0;
    int          nchk = 0;
    int          npass = 0;
    bit          run_active = 0;
    int          finish_due = -1;
    int          nacc = 0;
    int          lane = 0;
    int          wc = 0;
    logic [31:0] word = '0;
    int          dut_fin = 0;

    int          dir_gxp[5] = '{8, 0, 0, 1020, 100};
    int          dir_gxn[5] = '{0, 16, 0, 0, 100};
    int          dir_gyp[5] = '{0, 0, 24, 1020, 3};
    int          dir_gyn[5] = '{0, 0, 0, 0, 10};

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) begin
            npass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        run_active = 0;
        finish_due = -1;
        wq.delete();
        nacc = 0;
        lane = 0;
        wc   = 0;
        word = '0;
    endtask

    // One clock cycle: check this cycle's outputs, advance the model, step the clock.
    task automatic cycle();
        bit idle_now;
        bit exp_fin;
        bit exp_en;
        int pix;
        idle_now = !run_active && (finish_due < 0);
        exp_fin  = (finish_due == cyc);
        exp_en   = (wq.size() > 0) && (wq[0].due == cyc);

        chk("in_ready", in_ready, run_active);
        chk("finish", finish, exp_fin);
        chk("en", en, exp_en);
        chk("we", we, exp_en);
        if (exp_en) begin
            chk("addr", addr, wq[0].waddr);
            chk("dataW", dataW, wq[0].data);
            void'(wq.pop_front());
        end
        if (en === 1'b1) begin
            obs_d.push_back(dataW);
            obs_a.push_back(int'(addr));
        end
        if (finish === 1'b1) dut_fin++;
        if (exp_fin) finish_due = -1;

        if (in_valid && run_active) begin
            pix = (absd(gx_p, gx_n) + absd(gy_p, gy_n)) / 8;
            word[8*lane +: 8] = pix[7:0];
            lane++;
            nacc++;
            if (lane == 4) begin
                wq.push_back('{due: cyc + 2, waddr: BASE + wc, data: word});
                wc++;
                lane = 0;
                word = '0;
            end
            if (nacc == NPIX) begin
                run_active = 0;
                finish_due = cyc + 3;
            end
        end
        if (start && idle_now) begin
            run_active = 1;
            nacc = 0;
            lane = 0;
            wc   = 0;
            word = '0;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rand_data();
        gx_p = 10'($urandom_range(0, 1020));
        gx_n = 10'($urandom_range(0, 1020));
        gy_p = 10'($urandom_range(0, 1020));
        gy_n = 10'($urandom_range(0, 1020));
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        start    = 1'b0;
        rst      = 1'b1;
        #2;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_en", en, 1'b0);
        chk("rst_we", we, 1'b0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_dataW", dataW, 32'h0);
        chk("rst_finish", finish, 1'b0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
    endtask

    // mode 0: random valid, 1: toggling 1,0,1,0..., 2: always valid
    task automatic run_image(input int mode, input bit directed, input bit spurious);
        int  guard;
        bit  tog;
        guard = 0;
        tog   = 1'b1;
        obs_d.delete();
        obs_a.delete();
        dut_fin = 0;
        start = 1'b1;
        rand_data();
        cycle();
        start = 1'b0;
        while ((run_active || finish_due >= 0) && guard < 400) begin
            case (mode)
                0:       in_valid = ($urandom_range(0, 3) != 0);
                1:       in_valid = tog;
                default: in_valid = 1'b1;
            endcase
            tog = ~tog;
            if (directed && nacc < 5) begin
                gx_p = 10'(dir_gxp[nacc]);
                gx_n = 10'(dir_gxn[nacc]);
                gy_p = 10'(dir_gyp[nacc]);
                gy_n = 10'(dir_gyn[nacc]);
            end else begin
                rand_data();
            end
            start = spurious && ($urandom_range(0, 2) == 0);
            cycle();
            guard++;
        end
        start = 1'b0;
        chk("finish_pulses", dut_fin, 1);
        chk("write_count", obs_d.size(), WORDS);
        if (obs_a.size() > 0) chk("first_addr", obs_a[0], BASE);
        if (obs_a.size() == WORDS) chk("last_addr", obs_a[WORDS-1], BASE + WORDS - 1);
    endtask

    task automatic idle_valid(input int n);
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            rand_data();
            cycle();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #1;
        do_reset();

        idle_valid(4);

        // Scaling and sign/truncation pixels lead the first image.
        run_image(2, 1'b1, 1'b0);
        if (obs_d.size() >= 2) begin
            chk("scale_word", obs_d[0], 32'hFF030201);
            chk("sign_pixel", {24'h0, obs_d[1][7:0]}, 32'h0);
        end
        idle_valid(3);

        run_image(1, 1'b0, 1'b0);
        idle_valid(3);

        run_image(0, 1'b0, 1'b1);
        idle_valid(3);

        // Reset with a word written and two pixels of the next one packed.
        start = 1'b1;
        cycle();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_data();
            cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        do_reset();
        obs_d.delete();
        for (int i = 0; i < 4; i++) cycle();
        chk("post_reset_writes", obs_d.size(), 0);
        idle_valid(3);

        run_image(0, 1'b1, 1'b1);
        if (obs_d.size() >= 1) chk("restart_word", obs_d[0], 32'hFF030201);
        idle_valid(4);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
`default_nettype wire
